// File: rtl/sys_defs.sv
// sys_defs: shared types and constants for pipe_alu.
// Optional feature macro: PIPE_ALU_MUL_EN (adds the MUL_BUSY state encoding).
package sys_defs;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11
  } ALU_FUNC;

  // Result pattern for unsupported functions, replicated or truncated to WIDTH.
  localparam logic [31:0] ALU_DEADBEEF = 32'hdeadbeef;

`ifdef PIPE_ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } alu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd2
  } alu_state_e;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands; WIDTH iterations follow. done is high
// during the final iteration and prod then carries the completed 2*WIDTH
// product, so the consumer can register it on the same edge that finishes
// the last iteration.
// Only instantiated when PIPE_ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // Partial-product add: multiplicand joins the high half when the current
  // multiplier bit (lo[0]) is set; the carry lands in w_sum[WIDTH].
  assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : {WIDTH{1'b0}})};

  // Load on start, then shift the {hi,lo} pair right once per iteration,
  // counting down to terminal count 1 (the last iteration).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= CNT_W'(WIDTH);
      r_mcand <= opa;
      r_hi    <= '0;
      r_lo    <= opb;
    end else if (r_busy) begin
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done = r_busy && (r_cnt == CNT_W'(1));
  assign prod = {w_sum, r_lo[WIDTH-1:1]};

endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU. Single-cycle ops go straight into the output
// register (latency 1, one per cycle); MUL/MULHU run on an iterative
// multiplier (latency WIDTH+1) and block new requests until taken.
// Optional feature macro: PIPE_ALU_MUL_EN (without it MUL/MULHU are
// reported as illegal like any other unsupported function).
//
// state    | meaning
// IDLE     | accepting ops; single-cycle results flow to the output register
// MUL_BUSY | multiplier iterating, no new ops accepted
// HOLD     | multiply result presented, waiting for the consumer
module pipe_alu
  import sys_defs::*;
#(
  parameter int WIDTH = 32,  // power of two, 8..64
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  ALU_FUNC          alu_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  // WIDTH never exceeds 64, so two copies of the pattern cover every width.
  localparam logic [63:0]      DEAD_REP  = {ALU_DEADBEEF, ALU_DEADBEEF};
  localparam logic [WIDTH-1:0] DEAD_FILL = DEAD_REP[WIDTH-1:0];

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_illegal;

  logic               w_accept;
  logic               w_single;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ill;

`ifdef PIPE_ALU_MUL_EN
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [TAG_W-1:0]   r_mul_tag;
  logic               r_mul_hi;
`endif

  // Reset forces in_ready low; only one request is ever in flight past the
  // output register, and the consumer taking a result frees the slot.
  assign in_ready = reset_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_shamt  = opb[SHAMT_W-1:0];

`ifdef PIPE_ALU_MUL_EN
  assign w_is_mul    = (alu_func == ALU_MUL) || (alu_func == ALU_MULHU);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_single    = w_accept && !w_is_mul;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_mul_start),
    .opa     (opa),
    .opb     (opb),
    .done    (w_mul_done),
    .prod    (w_prod)
  );

  // Remember which half and whose tag the running multiply should report.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mul_tag <= '0;
      r_mul_hi  <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_tag <= in_tag;
      r_mul_hi  <= (alu_func == ALU_MULHU);
    end
  end
`else
  assign w_single = w_accept;
`endif

  // Single-cycle datapath; anything not listed (including MUL/MULHU when
  // they are not built) reports the fill pattern and the illegal flag.
  always_comb begin
    w_alu_res = DEAD_FILL;
    w_alu_ill = 1'b1;
    case (alu_func)
      ALU_ADD:  begin w_alu_res = opa + opb;                 w_alu_ill = 1'b0; end
      ALU_SUB:  begin w_alu_res = opa - opb;                 w_alu_ill = 1'b0; end
      ALU_AND:  begin w_alu_res = opa & opb;                 w_alu_ill = 1'b0; end
      ALU_OR:   begin w_alu_res = opa | opb;                 w_alu_ill = 1'b0; end
      ALU_XOR:  begin w_alu_res = opa ^ opb;                 w_alu_ill = 1'b0; end
      ALU_SLT:  begin
        w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
        w_alu_ill = 1'b0;
      end
      ALU_SLTU: begin
        w_alu_res = {{(WIDTH-1){1'b0}}, (opa < opb)};
        w_alu_ill = 1'b0;
      end
      ALU_SLL:  begin w_alu_res = opa << w_shamt;            w_alu_ill = 1'b0; end
      ALU_SRL:  begin w_alu_res = opa >> w_shamt;            w_alu_ill = 1'b0; end
      ALU_SRA:  begin w_alu_res = $signed(opa) >>> w_shamt;  w_alu_ill = 1'b0; end
      default:  ;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: only multiplies leave IDLE; single-cycle ops stay put.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef PIPE_ALU_MUL_EN
      ST_IDLE:     if (w_mul_start) w_state_nxt = ST_MUL_BUSY;
      ST_MUL_BUSY: if (w_mul_done)  w_state_nxt = ST_HOLD;
`else
      ST_IDLE:     w_state_nxt = ST_IDLE;
`endif
      ST_HOLD:     if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register: load on a single-cycle accept or multiply completion,
  // otherwise hold the payload and drop valid once the consumer takes it.
  // A multiply accept falls through to the handshake branch, which retires
  // any result being taken in that same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_illegal   <= 1'b0;
    end else if (w_single) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_out_tag   <= in_tag;
      r_illegal   <= w_alu_ill;
`ifdef PIPE_ALU_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= r_mul_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
      r_out_tag   <= r_mul_tag;
      r_illegal   <= 1'b0;
`endif
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_tag   = r_out_tag;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed vectors for pipe_alu (WIDTH=32, TAG_W=4). The driver
// pushes hand-computed expectations into a queue; an independent monitor
// pops on each output handshake and also checks first-appearance cycle and
// stability while stalled. Follows PIPE_ALU_MUL_EN for MUL/MULHU behaviour.
module tb_pipe_alu;
  import sys_defs::*;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ill;
    int          first;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opa;
  logic [31:0] opb;
  ALU_FUNC     alu_func;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  bit          mon_first = 1'b1;
  bit          mon_hold = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_tag;
  logic        held_ill;

  pipe_alu #(
    .WIDTH (32),
    .TAG_W (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opa       (opa),
    .opb       (opb),
    .alu_func  (alu_func),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after accept.
  task automatic issue(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp_res,
                       input logic exp_ill, input int lat);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    alu_func = f;
    opa      = a;
    opb      = b;
    in_tag   = tag;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d in_ready=%b expected=1", tag, in_ready);
      in_valid = 1'b0;
      @(negedge clock);
    end else begin
      e.res   = exp_res;
      e.tag   = tag;
      e.ill   = exp_ill;
      e.first = cyc + lat;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  // Monitor: samples two units after each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        mon_first = 1'b1;
        mon_hold  = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output result=%h tag=%h expected=no output", result, out_tag);
        end else begin
          if (mon_first) begin
            checks++;
            if (cyc != exp_q[0].first) begin
              errors++;
              $display("FAIL latency tag=%0d actual_cycle=%0d expected_cycle=%0d",
                       exp_q[0].tag, cyc, exp_q[0].first);
            end
            mon_first = 1'b0;
          end
          if (mon_hold) begin
            checks++;
            if (result !== held_res || out_tag !== held_tag || illegal !== held_ill) begin
              errors++;
              $display("FAIL hold_stable actual=%h/%h/%b expected=%h/%h/%b",
                       result, out_tag, illegal, held_res, held_tag, held_ill);
            end
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            checks++;
            if (result !== e.res || out_tag !== e.tag || illegal !== e.ill) begin
              errors++;
              $display("FAIL result tag=%0d actual=%h/%h/%b expected=%h/%h/%b",
                       e.tag, result, out_tag, illegal, e.res, e.tag, e.ill);
            end
            mon_first = 1'b1;
            mon_hold  = 1'b0;
          end else begin
            mon_hold = 1'b1;
            held_res = result;
            held_tag = out_tag;
            held_ill = illegal;
          end
        end
      end else begin
        mon_hold = 1'b0;
      end
    end
  end

  // Driver.
  initial begin
    in_valid  = 1'b0;
    opa       = '0;
    opb       = '0;
    alu_func  = ALU_ADD;
    in_tag    = '0;
    out_ready = 1'b1;
    reset_n   = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result",    {32'd0, result},    64'd0);
    chk("rst_out_tag",   {60'd0, out_tag},   64'd0);
    chk("rst_illegal",   {63'd0, illegal},   64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    @(negedge clock);

    // Single-cycle ops, back to back.
    issue(ALU_ADD,  32'd5,        32'd7,        4'd3,  32'd12,       1'b0, 1);
    issue(ALU_ADD,  32'd1,        32'd2,        4'd1,  32'd3,        1'b0, 1);
    issue(ALU_ADD,  32'hFFFFFFFF, 32'd1,        4'd2,  32'd0,        1'b0, 1);
    issue(ALU_SUB,  32'd3,        32'd5,        4'd4,  32'hFFFFFFFE, 1'b0, 1);
    issue(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 4'd5,  32'hF000F000, 1'b0, 1);
    issue(ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 4'd6,  32'hFFF0FFF0, 1'b0, 1);
    issue(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 4'd7,  32'h0FF00FF0, 1'b0, 1);
    issue(ALU_SRA,  32'h80000000, 32'h24,       4'd8,  32'hF8000000, 1'b0, 1);
    issue(ALU_SLT,  32'hFFFFFFFF, 32'd1,        4'd9,  32'd1,        1'b0, 1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        4'd10, 32'd0,        1'b0, 1);
    issue(ALU_SLL,  32'd1,        32'h21,       4'd11, 32'd2,        1'b0, 1);
    issue(ALU_SRL,  32'h80000000, 32'd31,       4'd12, 32'd1,        1'b0, 1);
    issue(ALU_FUNC'(4'd15), 32'd1, 32'd2,       4'd13, 32'hDEADBEEF, 1'b1, 1);
    repeat (2) @(negedge clock);

    // Consumer stalls for three cycles, then a new op rides the handshake.
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd10, 32'd20, 4'd5, 32'd30, 1'b0, 1);
    #1;
    chk("stall_in_ready_0", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    #1;
    chk("stall_in_ready_1", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    #1;
    chk("stall_in_ready_2", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    out_ready = 1'b1;
    issue(ALU_ADD, 32'd1, 32'd1, 4'd6, 32'd2, 1'b0, 1);
    repeat (2) @(negedge clock);

`ifdef PIPE_ALU_MUL_EN
    issue(ALU_MUL, 32'hFFFFFFFF, 32'd2, 4'd7, 32'hFFFFFFFE, 1'b0, 33);
    for (int i = 0; i < 33; i++) begin
      #1;
      chk("mul_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
    end
    issue(ALU_MULHU, 32'hFFFFFFFF, 32'd2, 4'd8, 32'd1, 1'b0, 33);
    for (int i = 0; i < 33; i++) begin
      #1;
      chk("mulhu_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
    end
    issue(ALU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9,  32'h00000001, 1'b0, 33);
    issue(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd10, 32'hFFFFFFFE, 1'b0, 33);
    issue(ALU_ADD,   32'd100,      32'd23,       4'd11, 32'd123,      1'b0, 1);
    repeat (2) @(negedge clock);

    // Reset ten cycles into a multiply: nothing may come out afterwards.
    issue(ALU_MUL, 32'hFFFFFFFF, 32'd2, 4'd9, 32'hFFFFFFFE, 1'b0, 33);
    repeat (9) @(negedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mul_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mul_rst_in_ready",  {63'd0, in_ready},  64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("mul_rst_in_ready_after", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clock);
    issue(ALU_ADD, 32'd2, 32'd2, 4'd1, 32'd4, 1'b0, 1);
`else
    issue(ALU_MUL,   32'hFFFFFFFF, 32'd2, 4'd7, 32'hDEADBEEF, 1'b1, 1);
    issue(ALU_MULHU, 32'hFFFFFFFF, 32'd2, 4'd8, 32'hDEADBEEF, 1'b1, 1);
    issue(ALU_ADD,   32'd100,      32'd23, 4'd9, 32'd123,     1'b0, 1);
`endif
    repeat (2) @(negedge clock);

    // Reset while a result is stalled at the output.
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd7, 32'd8, 4'd4, 32'd15, 1'b0, 1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("hold_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_rst_result",    {32'd0, result},    64'd0);
    chk("hold_rst_out_tag",   {60'd0, out_tag},   64'd0);
    chk("hold_rst_in_ready",  {63'd0, in_ready},  64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("hold_rst_in_ready_after", {63'd0, in_ready}, 64'd1);
    @(negedge clock);
    issue(ALU_SUB, 32'd0, 32'd1, 4'd14, 32'hFFFFFFFF, 1'b0, 1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
